pipelined_prefix_adder: RTL and testbench

Parametrised, pipelined Kogge-Stone parallel-prefix adder/subtractor. It succeeds the fixed 8-bit combinational prefix adder (a, b, cin → S) with four additions:

- a configurable width;
- one register per prefix level;
- a valid/ready handshake with back-pressure;
- subtract mode, with carry-out and signed-overflow flags.

It sits between operand sources and result consumers in the lab datapath, and sustains one operation per cycle.

---
 rtl/prefix_pkg.sv | 30 +++
 rtl/prefix_cell.sv | 15 +
 rtl/pipelined_prefix_adder.sv | 98 +++++++++
 tb/tb_pipelined_prefix_adder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/prefix_pkg.sv
// Shared helpers for the pipelined Kogge-Stone adder: level count and the
// black-cell (generate, propagate) combine.
package prefix_pkg;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

    function automatic int prefix_levels(input int width);
        return (width < 2) ? 1 : clog2(width);
    endfunction

    // hi covers the upper span, lo the span directly below it
    function automatic gp_t black_cell(input gp_t hi, input gp_t lo);
        gp_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

endpackage

// File: rtl/prefix_cell.sv
// One Kogge-Stone black cell: merges a high (g,p) span with the span below it.
module prefix_cell
    import prefix_pkg::*;
(
    input  logic gh,
    input  logic ph,
    input  logic gl,
    input  logic pl,
    output logic g,
    output logic p
);

    assign {g, p} = black_cell({gh, ph}, {gl, pl});

endmodule

// File: rtl/pipelined_prefix_adder.sv
// Pipelined Kogge-Stone adder/subtractor: pre-process stage, one register per
// prefix level, registered sum/flags, global-enable valid/ready pipeline.
module pipelined_prefix_adder
    import prefix_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             cout,
    output logic             ovf
);

    localparam int LEVELS = prefix_levels(WIDTH);
    localparam int STAGES = LEVELS + 1;

    logic                      adv;
    logic [STAGES:0]           vld_pipe;
    logic [WIDTH-1:0]          bb;
    logic                      c0;

    // Prefix vectors carry position -1 (the carry-in) at index 0.
    logic [LEVELS:0][WIDTH:0]  g_q, p_q, g_d, p_d;
    logic [LEVELS:0][WIDTH-1:0] hp_q, hp_d;
    logic [WIDTH:0]            ci_full;

    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_pipe[STAGES];

    assign bb      = sub ? ~b : b;
    assign c0      = sub | cin;
    assign g_d[0]  = {a & bb, c0};
    assign p_d[0]  = {a ^ bb, 1'b0};
    assign hp_d[0] = a ^ bb;

    genvar k, j;
    generate
        for (k = 1; k <= LEVELS; k++) begin : g_lvl
            localparam int D = 1 << (k - 1);
            assign hp_d[k] = hp_q[k-1];
            for (j = 0; j <= WIDTH; j++) begin : g_bit
                if (j >= D) begin : g_cell
                    prefix_cell u_cell (
                        .gh(g_q[k-1][j]),
                        .ph(p_q[k-1][j]),
                        .gl(g_q[k-1][j-D]),
                        .pl(p_q[k-1][j-D]),
                        .g (g_d[k][j]),
                        .p (p_d[k][j])
                    );
                end else begin : g_pass
                    assign g_d[k][j] = g_q[k-1][j];
                    assign p_d[k][j] = p_q[k-1][j];
                end
            end
        end
    endgenerate

    // Final fold with the carry-in; a no-op for spans that already reach it,
    // and it resolves the top position when it still sits one span short.
    assign ci_full = g_q[LEVELS] | (p_q[LEVELS] & {(WIDTH+1){g_q[LEVELS][0]}});

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      vld_pipe <= '0;
        else if (adv) vld_pipe <= {vld_pipe[STAGES-1:0], in_valid & in_ready};
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            g_q  <= g_d;
            p_q  <= p_d;
            hp_q <= hp_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            S    <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
        end else if (adv) begin
            S    <= hp_q[LEVELS] ^ ci_full[WIDTH-1:0];
            cout <= ci_full[WIDTH];
            ovf  <= ci_full[WIDTH-1] ^ ci_full[WIDTH];
        end
    end

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Bench for pipelined_prefix_adder: directed WIDTH=8 cases plus randomized
// WIDTH=13/32 streams checked against an arithmetic a+-b reference.
module tb_pipelined_prefix_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  in_valid, out_ready, cin, sub;
    wire  [2:0]  in_ready, out_valid, cout, ovf;
    logic [7:0]  a8, b8;
    logic [12:0] a13, b13;
    logic [31:0] a32, b32;
    wire  [7:0]  s8;
    wire  [12:0] s13;
    wire  [31:0] s32;

    int checks = 0;
    int errors = 0;

    pipelined_prefix_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a8), .b(b8), .cin(cin[0]), .sub(sub[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .S(s8), .cout(cout[0]), .ovf(ovf[0]));

    pipelined_prefix_adder #(.WIDTH(13)) u_dut13 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a13), .b(b13), .cin(cin[1]), .sub(sub[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .S(s13), .cout(cout[1]), .ovf(ovf[1]));

    pipelined_prefix_adder #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .a(a32), .b(b32), .cin(cin[2]), .sub(sub[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .S(s32), .cout(cout[2]), .ovf(ovf[2]));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int id, input logic [31:0] av, input logic [31:0] bv,
                          input logic c, input logic s);
        cin[id] = c;
        sub[id] = s;
        case (id)
            0:       begin a8  = av[7:0];  b8  = bv[7:0];  end
            1:       begin a13 = av[12:0]; b13 = bv[12:0]; end
            default: begin a32 = av;       b32 = bv;       end
        endcase
    endtask

    // Observed result packed as {ovf, cout, S zero-extended to 32 bits}
    function automatic logic [63:0] res(input int id);
        case (id)
            0:       return {30'b0, ovf[0], cout[0], 24'b0, s8};
            1:       return {30'b0, ovf[1], cout[1], 19'b0, s13};
            default: return {30'b0, ovf[2], cout[2], s32};
        endcase
    endfunction

    function automatic logic [63:0] ex(input int s, input bit co, input bit ov);
        return {30'b0, ov, co, 32'(s)};
    endfunction

    // Reference: plain unsigned sum for S/cout, signed range test for ovf.
    function automatic logic [63:0] model(input int w, input longint av, input longint bv,
                                          input bit c, input bit s);
        longint m, half, ua, ub, full, sa, sb, r;
        bit     o;
        m    = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ua   = av & m;
        ub   = bv & m;
        full = s ? ua + ((~ub) & m) + 1 : ua + ub + longint'(c);
        sa   = (ua >= half) ? ua - 2 * half : ua;
        sb   = (ub >= half) ? ub - 2 * half : ub;
        r    = s ? sa - sb : sa + sb + longint'(c);
        o    = (r < -half) || (r >= half);
        return {30'b0, o, 1'(full >> w), 32'(full & m)};
    endfunction

    task automatic op1(input string tag, input int av, input int bv, input bit c,
                       input bit s, input logic [63:0] e);
        set_op(0, av, bv, c, s);
        in_valid[0]  = 1'b1;
        out_ready[0] = 1'b1;
        step();
        in_valid[0] = 1'b0;
        repeat (3) step();
        chk({tag, "_early"}, out_valid[0], 0);
        step();
        chk({tag, "_vld"}, out_valid[0], 1);
        chk(tag, res(0), e);
        step();
    endtask

    function automatic int bp_a(input int i); return (i * 37 + 90) & 255; endfunction
    function automatic int bp_b(input int i); return (i * 53 + 120) & 255; endfunction
    function automatic bit bp_s(input int i); return (i % 3) == 2; endfunction

    task automatic rand_run(input int id, input int w, input int nops);
        logic [63:0] q[$];
        logic [63:0] held;
        logic [31:0] ra, rb;
        bit rc, rs, acc, hold;
        int sent, got, cyc;
        sent = 0; got = 0; cyc = 0; hold = 0; held = '0;
        ra = '0; rb = '0; rc = 0; rs = 0;
        in_valid[id] = 1'b0;
        while (got < nops && cyc < 20000) begin
            if (!in_valid[id] && sent < nops && $urandom_range(3) != 0) begin
                ra = $urandom;
                rb = $urandom;
                if ($urandom_range(7) == 0) ra = '1;
                if ($urandom_range(7) == 0) rb = 32'h1 << (w - 1);
                rc = 1'($urandom_range(1));
                rs = 1'($urandom_range(1));
                set_op(id, ra, rb, rc, rs);
                in_valid[id] = 1'b1;
            end
            out_ready[id] = ($urandom_range(3) != 0);
            #1;
            if (hold) begin
                chk("hold_vld", out_valid[id], 1);
                chk("hold_val", res(id), held);
            end
            if (out_valid[id] && out_ready[id]) begin
                if (q.size() == 0) chk("rand_extra", q.size(), 1);
                else chk($sformatf("rand_w%0d", w), res(id), q.pop_front());
                got++;
            end
            hold = out_valid[id] && !out_ready[id];
            held = res(id);
            acc  = in_valid[id] && in_ready[id];
            if (acc) begin
                q.push_back(model(w, ra, rb, rc, rs));
                sent++;
            end
            step();
            if (acc) in_valid[id] = 1'b0;
            cyc++;
        end
        in_valid[id]  = 1'b0;
        out_ready[id] = 1'b1;
        chk($sformatf("rand_done_w%0d", w), got, nops);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, r;
        bit acc;
        rst = 1'b1;
        in_valid = '0; out_ready = '1; cin = '0; sub = '0;
        a8 = '0; b8 = '0; a13 = '0; b13 = '0; a32 = '0; b32 = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_vld", out_valid[0], 0);
        chk("rst_out", res(0), 0);
        chk("rst_rdy", in_ready[0], 1);
        step();

        // Back-to-back stream, latency and ordering
        set_op(0, 100, 24, 0, 0); in_valid[0] = 1'b1; step();
        set_op(0, 20, 178, 0, 0); step();
        set_op(0, 177, 54, 0, 0); step();
        in_valid[0] = 1'b0;
        step();
        chk("lat_early", out_valid[0], 0);
        step();
        chk("lat_vld", out_valid[0], 1);
        chk("str0", res(0), ex(124, 0, 0));
        step();
        chk("str1", res(0), ex(198, 0, 0));
        step();
        chk("str2", res(0), ex(231, 0, 0));
        step();
        chk("str_end", out_valid[0], 0);

        op1("carry",  200, 100, 0, 0, ex(44, 1, 0));
        op1("ovf",    127, 1,   0, 0, ex(128, 0, 1));
        op1("cin",    255, 0,   1, 0, ex(0, 1, 0));
        op1("sub_ge", 100, 50,  0, 1, ex(50, 1, 0));
        op1("sub_lt", 50,  100, 0, 1, ex(206, 0, 0));
        op1("sub_ov", 128, 1,   1, 1, ex(127, 1, 1));

        // Back-pressure: 7 ops offered with the consumer stalled
        out_ready[0] = 1'b0;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            if (n < 7) begin set_op(0, bp_a(n), bp_b(n), 0, bp_s(n)); in_valid[0] = 1'b1; end
            else in_valid[0] = 1'b0;
            #1;
            acc = in_valid[0] && in_ready[0];
            step();
            if (acc) n++;
        end
        chk("bp_acc", n, 5);
        chk("bp_rdy", in_ready[0], 0);
        chk("bp_vld", out_valid[0], 1);
        chk("bp_hold", res(0), model(8, bp_a(0), bp_b(0), 0, bp_s(0)));
        out_ready[0] = 1'b1;
        r = 0;
        for (int c = 0; c < 20; c++) begin
            if (n < 7) begin set_op(0, bp_a(n), bp_b(n), 0, bp_s(n)); in_valid[0] = 1'b1; end
            else in_valid[0] = 1'b0;
            #1;
            acc = in_valid[0] && in_ready[0];
            if (out_valid[0]) begin
                if (r < 7) chk($sformatf("bp_out%0d", r), res(0), model(8, bp_a(r), bp_b(r), 0, bp_s(r)));
                r++;
            end
            step();
            if (acc) n++;
        end
        chk("bp_count", r, 7);

        // Reset with ops in flight
        set_op(0, 11, 22, 0, 0); in_valid[0] = 1'b1; step();
        set_op(0, 33, 44, 0, 0); step();
        set_op(0, 55, 66, 0, 0); step();
        in_valid[0] = 1'b0;
        repeat (2) step();
        chk("mid_pre", out_valid[0], 1);
        rst = 1'b1;
        #1;
        chk("mid_vld", out_valid[0], 0);
        chk("mid_out", res(0), 0);
        step();
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            chk("mid_stale", out_valid[0], 0);
        end

        rand_run(1, 13, 1000);
        rand_run(2, 32, 1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
